// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sub_bytes_seq  (plus leaf inv_s_box)
//  Purpose  : Iterative AES InvSubBytes stage for the decrypt datapath.
//             A 128-bit state is accepted over a valid/ready handshake,
//             substituted BYTES_PER_CYCLE bytes per clock and returned over
//             a second valid/ready handshake.
//  Ports    : clk, rst_n (async, active low)
//             in_valid / in_ready / in_state[127:0]    input handshake
//             out_valid / out_ready / out_state[127:0] output handshake
//             busy                                     high in RUN or HOLD
//  Byte i of a state lives at state[127-8i -: 8] (FIPS-197 order).
//  Config   : `define INV_SB_SHIFTROWS_EN to apply InvShiftRows at capture,
//             turning the block into the full InvShiftRows+InvSubBytes pair.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  inv_s_box: AES inverse S-box, computed as inverse affine transform followed
//  by the multiplicative inverse in GF(2^8) (x^254, with 0 mapping to 0).
//  Ports: byte_i[7:0] in, byte_o[7:0] out (pure combinational).
// ----------------------------------------------------------------------------
module inv_s_box (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic [7:0] bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ aa;
      // xtime: multiply by x modulo x^8+x^4+x^3+x+1
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return acc;
  endfunction

  logic [7:0] w_affine;
  logic [7:0] w_pow;
  logic [7:0] w_prod;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  assign w_affine = {byte_i[6:0], byte_i[7]} ^ {byte_i[4:0], byte_i[7:5]} ^
                    {byte_i[1:0], byte_i[7:2]} ^ 8'h05;

  // x^254 = x^2 * x^4 * ... * x^128 via repeated squaring
  always_comb begin
    w_pow  = w_affine;
    w_prod = 8'h01;
    for (int i = 0; i < 7; i++) begin
      w_pow  = gf_mul(w_pow, w_pow);
      w_prod = gf_mul(w_prod, w_pow);
    end
  end

  assign byte_o = w_prod;

endmodule

// ----------------------------------------------------------------------------
//  inv_sub_bytes_seq: IDLE -> RUN (16/BPC cycles) -> HOLD -> IDLE.
//  out_valid rises exactly 16/BPC edges after the input transfer edge.
// ----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCHUNK  = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;

  logic [127:0]       w_capture;
  logic [CHUNK_W-1:0] w_chunk;
  logic [CHUNK_W-1:0] w_sub;

  // Capture path: straight copy, or InvShiftRows with byte i = r + 4c,
  // work[r][c] = in[r][(c-r) mod 4].
`ifdef INV_SB_SHIFTROWS_EN
  always_comb begin
    w_capture = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_capture[127-8*(r+4*c) -: 8] = in_state[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
  end
`else
  assign w_capture = in_state;
`endif

  // Select the chunk addressed by the counter (chunk 0 = bytes 0..BPC-1)
  always_comb begin
    w_chunk = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (cnt_q == CNT_W'(c)) w_chunk = work_q[127-c*CHUNK_W -: CHUNK_W];
    end
  end

  generate
    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
      inv_s_box u_inv_s_box (
        .byte_i(w_chunk[CHUNK_W-1-8*k -: 8]),
        .byte_o(w_sub[CHUNK_W-1-8*k -: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = w_capture;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int c = 0; c < NCHUNK; c++) begin
          if (cnt_q == CNT_W'(c)) work_d[127-c*CHUNK_W -: CHUNK_W] = w_sub;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        // Result frozen until accepted; no new input while holding.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_sub_bytes_seq
//  Purpose  : Self-checking bench for inv_sub_bytes_seq: table vectors,
//             handshake corner sequences, and a BPC sweep with random states
//             against a table-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic         sw_in_valid;
  logic         sw_out_ready;
  logic [127:0] sw_in_state;
  logic         sw_in_ready  [5];
  logic         sw_out_valid [5];
  logic         sw_busy      [5];
  logic [127:0] sw_out_state [5];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_state(out_state),
    .busy     (busy)
  );

  generate
    for (genvar g = 0; g < 5; g++) begin : g_sweep
      inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (sw_in_valid),
        .in_ready (sw_in_ready[g]),
        .in_state (sw_in_state),
        .out_valid(sw_out_valid[g]),
        .out_ready(sw_out_ready),
        .out_state(sw_out_state[g]),
        .busy     (sw_busy[g])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Build the forward S-box by brute-force inversion, then invert the table.
  function automatic void build_table();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] din);
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = din[127-8*i -: 8];
`ifdef INV_SB_SHIFTROWS_EN
    // Row r of the column-major state is rotated right by r positions.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r + 4*c] = b[r + 4*((c + 4 - r) % 4)];
`else
    for (int i = 0; i < 16; i++) m[i] = b[i];
`endif
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = inv_tab[m[i]];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main DUT, checking handshake and latency.
  task automatic run_block(input string name, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    check({name, " in_ready idle"}, 128'(in_ready), 128'd1);
    in_state = din;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, " busy after accept"}, 128'(busy), 128'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check({name, " latency"}, 128'(lat), 128'd4);
    check({name, " out_state"}, out_state, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, " out_valid after transfer"}, 128'(out_valid), 128'd0);
    check({name, " in_ready after transfer"}, 128'(in_ready), 128'd1);
  endtask

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [127:0] a;
    logic [127:0] bst;
    logic [127:0] held;
    int           lat [5];
    int           w;

    rst_n        = 1'b1;
    in_valid     = 1'b0;
    in_state     = '0;
    out_ready    = 1'b0;
    sw_in_valid  = 1'b0;
    sw_in_state  = '0;
    sw_out_ready = 1'b0;
    build_table();

    // Asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset out_state", out_state, 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Table vectors
    vecs[0] = '{"all00", {16{8'h00}}, {16{8'h52}}};
`ifdef INV_SB_SHIFTROWS_EN
    vecs[1] = '{"ramp", 128'h000102030405060708090a0b0c0d0e0f,
                128'h52f3a338_3009d79e_bf366afb_8140a5d5};
`else
    vecs[1] = '{"ramp", 128'h000102030405060708090a0b0c0d0e0f,
                128'h52096ad5_3036a538_bf40a39e_81f3d7fb};
`endif
    vecs[2] = '{"all63", {16{8'h63}}, {16{8'h00}}};
    vecs[3] = '{"allFF", {16{8'hff}}, {16{8'h7d}}};
    for (int i = 0; i < 4; i++) run_block(vecs[i].name, vecs[i].din, vecs[i].exp);

    // Random blocks on the main DUT
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      run_block("rand", a, ref_model(a));
    end

    // Backpressure with in_valid held high throughout
    a   = {$urandom, $urandom, $urandom, $urandom};
    bst = {$urandom, $urandom, $urandom, $urandom};
    in_state = a;
    in_valid = 1'b1;
    step();
    in_state = bst;
    w = 0;
    while (!out_valid && w < 50) begin
      check("bp in_ready during run", 128'(in_ready), 128'd0);
      step();
      w++;
    end
    check("bp latency", 128'(w), 128'd4);
    held = out_state;
    check("bp result", held, ref_model(a));
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp out_valid held", 128'(out_valid), 128'd1);
      check("bp out_state stable", out_state, held);
      check("bp in_ready low in hold", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp out_valid dropped", 128'(out_valid), 128'd0);
    check("bp in_ready idle", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("bp next accepted", 128'(busy), 128'd1);
    w = 0;
    while (!out_valid && w < 50) begin step(); w++; end
    check("bp second latency", 128'(w), 128'd4);
    check("bp second result", out_state, ref_model(bst));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-RUN
    in_state = {16{8'h63}};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrun busy", 128'(busy), 128'd0);
    check("midrun in_ready", 128'(in_ready), 128'd1);
    check("midrun out_state", out_state, 128'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) rst_n = 1'b1;
      check("midrun no out_valid", 128'(out_valid), 128'd0);
    end
    run_block("after reset all63", {16{8'h63}}, {16{8'h00}});

    // BPC sweep with random states
    for (int t = 0; t < 20; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 5; i++) begin
        check("sweep idle", 128'(sw_in_ready[i]), 128'd1);
        lat[i] = -1;
      end
      sw_in_state = a;
      sw_in_valid = 1'b1;
      step();
      sw_in_valid = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        step();
        for (int i = 0; i < 5; i++) if (sw_out_valid[i] && lat[i] < 0) lat[i] = cyc;
      end
      for (int i = 0; i < 5; i++) begin
        check($sformatf("sweep bpc%0d latency", 1 << i), 128'(lat[i]), 128'(16 >> i));
        check($sformatf("sweep bpc%0d out_state", 1 << i), sw_out_state[i], ref_model(a));
      end
      sw_out_ready = 1'b1;
      step();
      sw_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) check("sweep out_valid cleared", 128'(sw_out_valid[i]), 128'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
